multiff_scanner: RTL and testbench

//  Read-side counterpart of the per-channel byte register bank: snapshots a CHANNELS*BUSWIDTH

---
 rtl/multiff_pkg.sv | 27 ++
 rtl/multiff_scanner.sv | 128 ++++++++++++
 tb/tb_multiff_scanner.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multiff_pkg.sv
// ---------------------------------------------------------------------------
// multiff_pkg
//   Shared definitions for the per-channel byte register bank and its
//   read-side scanner.  Both ends import the same channel geometry so that a
//   channel index produced by the scanner selects the same register the write
//   side would address with that index.
//
//   Contents:
//     DEF_BUSWIDTH    bits per channel byte
//     DEF_CHANNELS    number of channels in the bank
//     DEF_CHANNELBITS width of a channel index
//     state_t         scanner state encoding (ST_IDLE, ST_SEND)
// ---------------------------------------------------------------------------
package multiff_pkg;

  localparam int DEF_BUSWIDTH    = 8;
  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_CHANNELBITS = 2;

  // One state bit is enough: the scanner either waits for a start request or
  // is offering the bytes of a captured snapshot.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : multiff_pkg

// File: rtl/multiff_scanner.sv
// ---------------------------------------------------------------------------
// multiff_scanner
//   Snapshots a CHANNELS*BUSWIDTH parallel bus on a start request and emits
//   it one channel at a time as (byte, channel index) over a valid/ready link,
//   lowest channel first.  Intended to sit between the wide register outputs
//   of the byte bank and a narrow byte-serial consumer.
//
//   Ports:
//     clk       in   1                   system clock, rising edge
//     reset     in   1                   asynchronous, active-high reset
//     inlines   in   CHANNELS*BUSWIDTH   parallel source, channel i at
//                                         [(i+1)*BUSWIDTH-1 : i*BUSWIDTH]
//     start     in   1                   request one full scan (idle only)
//     outlines  out  BUSWIDTH            byte of the channel being offered
//     channel   out  CHANNELBITS         index of the channel being offered
//     valid     out  1                   a byte is offered to the consumer
//     ready     in   1                   consumer accepts when valid && ready
//     busy      out  1                   scan in progress
//     done      out  1                   one-cycle pulse after the last byte
// ---------------------------------------------------------------------------
module multiff_scanner
  import multiff_pkg::*;
#(
  parameter int BUSWIDTH    = DEF_BUSWIDTH,
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CHANNELBITS = DEF_CHANNELBITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*BUSWIDTH-1:0] inlines,
  input  logic                         start,
  output logic [BUSWIDTH-1:0]          outlines,
  output logic [CHANNELBITS-1:0]       channel,
  output logic                         valid,
  input  logic                         ready,
  output logic                         busy,
  output logic                         done
);

  // The scan ends at the last real channel, not at the top of the index
  // range, so non-power-of-two channel counts never emit a phantom index.
  localparam logic [CHANNELBITS-1:0] LAST_IDX = CHANNELBITS'(CHANNELS - 1);

  state_t                       r_state;
  logic [CHANNELBITS-1:0]       r_idx;
  logic [CHANNELS*BUSWIDTH-1:0] r_snapshot;
  logic [BUSWIDTH-1:0]          r_outlines;
  logic                         r_valid;
  logic                         r_busy;
  logic                         r_done;

  logic [CHANNELBITS-1:0]       w_nextIdx;
  logic [BUSWIDTH-1:0]          w_nextByte;
  logic                         w_transfer;
  logic                         w_lastByte;

  assign w_transfer = r_valid && ready;
  assign w_lastByte = (r_idx == LAST_IDX);
  assign w_nextIdx  = r_idx + CHANNELBITS'(1);

  // Byte of the channel that follows the one currently offered.  Only
  // indices below CHANNELS can match, so out-of-range indices read as zero
  // and the snapshot is never sliced past its top.
  always_comb begin
    w_nextByte = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_nextIdx == CHANNELBITS'(i)) begin
        w_nextByte = r_snapshot[i*BUSWIDTH +: BUSWIDTH];
      end
    end
  end

  // Scan controller.  The offered byte and index live in flops that only
  // change on a transfer, which keeps data stable while the consumer stalls.
  // A start request is only looked at in idle, so the done cycle (already
  // idle) can launch the next scan back to back with the new capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_snapshot <= '0;
      r_outlines <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_snapshot <= inlines;
            r_idx      <= '0;
            r_outlines <= inlines[BUSWIDTH-1:0];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_transfer) begin
            if (w_lastByte) begin
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_idx      <= w_nextIdx;
              r_outlines <= w_nextByte;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign outlines = r_outlines;
  assign channel  = r_idx;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule : multiff_scanner

// File: tb/tb_multiff_scanner.sv
// ---------------------------------------------------------------------------
// tb_multiff_scanner
//   Drives a four-channel and a three-channel scanner from the same start,
//   ready and source stimulus and compares both against a transaction-level
//   reference: on an accepted start the bench records the source bytes as a
//   list, then expects that list to be offered in order, advancing only on
//   an accepted transfer, with a single done cycle after the final byte.
// ---------------------------------------------------------------------------
module tb_multiff_scanner;

  logic        clk;
  logic        reset;
  logic [31:0] inlines;
  logic [23:0] inlines3;
  logic        start;
  logic        ready;

  logic [7:0]  outlines4;
  logic [1:0]  channel4;
  logic        valid4;
  logic        busy4;
  logic        done4;

  logic [7:0]  outlines3;
  logic [1:0]  channel3;
  logic        valid3;
  logic        busy3;
  logic        done3;

  int vectors;
  int miscompares;

  // Reference state per instance: 0 = four channels, 1 = three channels.
  logic [7:0] mBytes [2][4];
  int         mPos   [2];
  logic       mBusy  [2];
  logic       mDone  [2];

  assign inlines3 = inlines[23:0];

  multiff_scanner #(.BUSWIDTH(8), .CHANNELS(4), .CHANNELBITS(2)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .inlines  (inlines),
    .start    (start),
    .outlines (outlines4),
    .channel  (channel4),
    .valid    (valid4),
    .ready    (ready),
    .busy     (busy4),
    .done     (done4)
  );

  multiff_scanner #(.BUSWIDTH(8), .CHANNELS(3), .CHANNELBITS(2)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .inlines  (inlines3),
    .start    (start),
    .outlines (outlines3),
    .channel  (channel3),
    .valid    (valid3),
    .ready    (ready),
    .busy     (busy3),
    .done     (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time,
               observed, expected);
    end
  endtask

  function automatic int chanCount(input int n);
    return (n == 0) ? 4 : 3;
  endfunction

  task automatic modelClear();
    for (int n = 0; n < 2; n++) begin
      mPos[n]  = 0;
      mBusy[n] = 1'b0;
      mDone[n] = 1'b0;
      for (int i = 0; i < 4; i++) mBytes[n][i] = 8'h00;
    end
  endtask

  // What one rising edge does to the transaction list of instance n.
  task automatic modelEdge(input int n, input logic iStart, input logic iReady,
                           input logic [31:0] iIn);
    mDone[n] = 1'b0;
    if (mBusy[n]) begin
      if (iReady) begin
        if (mPos[n] == chanCount(n) - 1) begin
          mBusy[n] = 1'b0;
          mDone[n] = 1'b1;
        end else begin
          mPos[n] = mPos[n] + 1;
        end
      end
    end else if (iStart) begin
      for (int i = 0; i < chanCount(n); i++) mBytes[n][i] = iIn[i*8 +: 8];
      mPos[n]  = 0;
      mBusy[n] = 1'b1;
    end
  endtask

  task automatic checkInst(input int n, input logic v, input logic b,
                           input logic d, input logic [1:0] ch,
                           input logic [7:0] ob);
    checkOutput($sformatf("valid%0d", n), {31'd0, v}, {31'd0, mBusy[n]});
    checkOutput($sformatf("busy%0d", n),  {31'd0, b}, {31'd0, mBusy[n]});
    checkOutput($sformatf("done%0d", n),  {31'd0, d}, {31'd0, mDone[n]});
    if (mBusy[n]) begin
      checkOutput($sformatf("channel%0d", n), {30'd0, ch}, 32'(mPos[n]));
      checkOutput($sformatf("byte%0d", n), {24'd0, ob}, {24'd0, mBytes[n][mPos[n]]});
    end
  endtask

  // One cycle: check the outputs settled after the previous edge, then drive
  // the inputs for the coming edge and advance the reference accordingly.
  task automatic applyStimulus(input logic iStart, input logic iReady,
                               input logic [31:0] iIn);
    @(negedge clk);
    checkInst(0, valid4, busy4, done4, channel4, outlines4);
    checkInst(1, valid3, busy3, done3, channel3, outlines3);
    checkOutput("ch3range", {31'd0, (channel3 < 2'd3)}, 32'd1);
    start   = iStart;
    ready   = iReady;
    inlines = iIn;
    modelEdge(0, iStart, iReady, iIn);
    modelEdge(1, iStart, iReady, iIn);
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    #1;
    modelClear();
    checkOutput("rstValid4", {31'd0, valid4}, 32'd0);
    checkOutput("rstBusy4",  {31'd0, busy4},  32'd0);
    checkOutput("rstDone4",  {31'd0, done4},  32'd0);
    checkOutput("rstByte4",  {24'd0, outlines4}, 32'd0);
    checkOutput("rstChan4",  {30'd0, channel4}, 32'd0);
    checkOutput("rstValid3", {31'd0, valid3}, 32'd0);
    checkOutput("rstDone3",  {31'd0, done3},  32'd0);
    checkOutput("rstByte3",  {24'd0, outlines3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    ready       = 1'b0;
    inlines     = 32'h0;
    modelClear();
    applyReset();

    // Full scan with the consumer always ready.
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 32'h44332211);

    // Consumer stalls: pattern 1,0,0,1 repeated.
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, (i % 4 == 0) || (i % 4 == 3), 32'h44332211);

    // Source changes and start requests during a scan must not matter.
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);

    // Start in the done cycle launches the next scan back to back.
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h44332211);
    applyStimulus(1'b1, 1'b1, 32'hA0B0C0D0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 32'h0);

    // Reset while channel 2 is offered: abort, no done pulse afterwards.
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b0, 32'h44332211);
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) == 0) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(3, 0) == 0, $urandom_range(2, 0) != 0,
                      $urandom);
      end
    end
    applyStimulus(1'b0, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multiff_scanner
